// File: rtl/alu4_arbiter.sv
// alu4_arbiter: shares one 4-bit ALU (ADD, SUB, AND, OR) between two requesters.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   req0_* / req1_*          command ports: valid, ready, a[3:0], b[3:0], op[1:0]
//                            op: 0=ADD, 1=SUB, 2=AND, 3=OR
//   rsp_valid, rsp_ready     registered response handshake
//   rsp_id, rsp_s, rsp_c     requester id, 4-bit result, carry flag
//   gnt_cnt0, gnt_cnt1       per-requester transfer counters (only when the
//                            ALU4_ARB_STATS_EN macro is defined)
//
// Handshake semantics (all ports): a beat transfers on a rising clk edge where
// valid and ready are both high. A requester keeps a/b/op stable while valid
// is high and ready is low; valid may drop at any time (no lock), and the
// arbiter re-evaluates the grant every cycle. The response register holds
// its contents while rsp_valid is high and rsp_ready is low.
//
// Arbitration is round-robin: on contention the requester that did not win
// the last transfer wins. last_grant resets to 1 so requester 0 wins first.

module alu4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [1:0] op,
  output logic [3:0] s,
  output logic       c
);
  logic [4:0] sum;

  always_comb begin
    sum = 5'd0;
    s   = 4'd0;
    c   = 1'b0;
    case (op)
      2'd0: begin
        sum = {1'b0, a} + {1'b0, b};
        s   = sum[3:0];
        c   = sum[4];
      end
      2'd1: begin
        // Two's complement subtract; carry out = 1 means no borrow (a >= b).
        sum = {1'b0, a} + {1'b0, ~b} + 5'd1;
        s   = sum[3:0];
        c   = sum[4];
      end
      2'd2:    s = a & b;
      default: s = a | b;
    endcase
  end
endmodule

module alu4_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_a,
  input  logic [3:0] req0_b,
  input  logic [1:0] req0_op,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_a,
  input  logic [3:0] req1_b,
  input  logic [1:0] req1_op,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_s,
  output logic       rsp_c
`ifdef ALU4_ARB_STATS_EN
  ,
  output logic [7:0] gnt_cnt0,
  output logic [7:0] gnt_cnt1
`endif
);

  logic       last_grant;
  logic       can_accept;
  logic       gnt_valid;
  logic       gnt_id;
  logic       xfer;
  logic [3:0] sel_a;
  logic [3:0] sel_b;
  logic [1:0] sel_op;
  logic [3:0] alu_s;
  logic       alu_c;

  // The response register may be refilled in the same cycle it drains.
  assign can_accept = ~rsp_valid | rsp_ready;

  always_comb begin
    gnt_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) gnt_id = ~last_grant;
    else                          gnt_id = ~req0_valid;
  end

  assign req0_ready = ~rst & can_accept & gnt_valid & ~gnt_id & req0_valid;
  assign req1_ready = ~rst & can_accept & gnt_valid &  gnt_id & req1_valid;
  assign xfer       = req0_ready | req1_ready;

  always_comb begin
    if (gnt_id) begin
      sel_a  = req1_a;
      sel_b  = req1_b;
      sel_op = req1_op;
    end else begin
      sel_a  = req0_a;
      sel_b  = req0_b;
      sel_op = req0_op;
    end
  end

  alu4 u_alu (
    .a  (sel_a),
    .b  (sel_b),
    .op (sel_op),
    .s  (alu_s),
    .c  (alu_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_s      <= 4'd0;
      rsp_c      <= 1'b0;
      last_grant <= 1'b1;
    end else if (xfer) begin
      rsp_valid  <= 1'b1;
      rsp_id     <= gnt_id;
      rsp_s      <= alu_s;
      rsp_c      <= alu_c;
      last_grant <= gnt_id;
    end else if (rsp_valid && rsp_ready) begin
      // Drained with nothing to replace it; data bits are left as they were.
      rsp_valid <= 1'b0;
    end
  end

`ifdef ALU4_ARB_STATS_EN
  // Transfer counters wrap naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_cnt0 <= 8'd0;
      gnt_cnt1 <= 8'd0;
    end else begin
      if (req0_ready) gnt_cnt0 <= gnt_cnt0 + 8'd1;
      if (req1_ready) gnt_cnt1 <= gnt_cnt1 + 8'd1;
    end
  end
`else
  // No statistics counters in this build.
`endif

endmodule

// File: tb/tb_alu4_arbiter.sv
// tb_alu4_arbiter: directed-vector bench for alu4_arbiter. Stimulus pushes
// hand-computed responses {id, s, c} into exp_q when a command is accepted;
// a monitor pops and compares whenever a response is consumed.
// Define ALU4_ARB_STATS_EN to also exercise the transfer counters.

module tb_alu4_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready;
  logic       rsp_id;
  logic [3:0] rsp_s;
  logic       rsp_c;
`ifdef ALU4_ARB_STATS_EN
  logic [7:0] gnt_cnt0, gnt_cnt1;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] exp_q[$];

  alu4_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_s      (rsp_s),
    .rsp_c      (rsp_c)
`ifdef ALU4_ARB_STATS_EN
    ,
    .gnt_cnt0   (gnt_cnt0),
    .gnt_cnt1   (gnt_cnt1)
`endif
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit id, input logic [3:0] a, input logic [3:0] b,
                           input logic [1:0] op, input logic v);
    if (id == 1'b0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  // Single command on an otherwise idle arbiter with rsp_ready=1: must be
  // accepted in the cycle valid rises, and the response visible next cycle.
  task automatic send(input bit id, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] op, input logic [3:0] es, input logic ec);
    int  waits;
    bit  got;
    waits = 0;
    got   = 0;
    drive_req(id, a, b, op, 1'b1);
    while (!got && waits < 20) begin
      @(negedge clk);
      if ((id == 1'b0 && req0_ready) || (id == 1'b1 && req1_ready)) begin
        got = 1;
        exp_q.push_back({id, es, ec});
      end else begin
        waits++;
      end
    end
    check("ready_wait", waits, 0);
    tick();
    drive_req(id, 4'd0, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    check("rsp_valid_next", rsp_valid, 1);
    tick();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_unexpected: got id=%0d s=0x%0h c=%0d, expected no response",
                 rsp_id, rsp_s, rsp_c);
      end else begin
        check("rsp_data", {26'd0, rsp_id, rsp_s, rsp_c}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] ord_rsp [4];
  bit         ord_id  [4];

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    drive_req(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    drive_req(1'b1, 4'd0, 4'd0, 2'd0, 1'b0);
    tick();
    tick();
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_s", rsp_s, 0);
    check("reset_rsp_c", rsp_c, 0);
    tick();
    rst = 1'b0;

    // Arithmetic vectors.
    send(1'b0, 4'd5,  4'd3,  2'd0, 4'h8, 1'b0);
    send(1'b1, 4'd9,  4'd8,  2'd0, 4'h1, 1'b1);
    send(1'b1, 4'd3,  4'd5,  2'd1, 4'hE, 1'b0);
    send(1'b1, 4'd5,  4'd3,  2'd1, 4'h2, 1'b1);
    send(1'b0, 4'hC,  4'hA,  2'd2, 4'h8, 1'b0);
    send(1'b0, 4'hC,  4'hA,  2'd3, 4'hE, 1'b0);
    send(1'b1, 4'h0,  4'h0,  2'd1, 4'h0, 1'b1);
    send(1'b0, 4'hF,  4'h1,  2'd0, 4'h0, 1'b1);

    // Contention right after reset: grant order 0,1,0,1.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ord_id  = '{1'b0, 1'b1, 1'b0, 1'b1};
    ord_rsp = '{6'b0_0011_0, 6'b1_0111_1, 6'b0_1110_0, 6'b1_0111_0};
    drive_req(1'b0, 4'd1, 4'd2, 2'd0, 1'b1);   // 1+2   -> 3,0
    drive_req(1'b1, 4'd8, 4'd1, 2'd1, 1'b1);   // 8-1   -> 7,1
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("contend_ready0", req0_ready, ord_id[i] == 1'b0);
      check("contend_ready1", req1_ready, ord_id[i] == 1'b1);
      exp_q.push_back(ord_rsp[i]);
      tick();
      if (i == 0) drive_req(1'b0, 4'd7, 4'd7, 2'd0, 1'b1);  // 7+7 -> E,0
      if (i == 1) drive_req(1'b1, 4'd3, 4'd4, 2'd3, 1'b1);  // 3|4 -> 7,0
      if (i == 2) drive_req(1'b0, 4'd4, 4'd4, 2'd1, 1'b1);
      if (i == 3) drive_req(1'b1, 4'd6, 4'd3, 2'd2, 1'b1);
    end
    drive_req(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    drive_req(1'b1, 4'd0, 4'd0, 2'd0, 1'b0);
    tick();
    tick();

    // Backpressure: last_grant is 1, so req0 fills the register, then stall.
    rsp_ready = 1'b0;
    drive_req(1'b0, 4'd2, 4'd2, 2'd0, 1'b1);   // 2+2 -> 4,0
    drive_req(1'b1, 4'd3, 4'd3, 2'd0, 1'b1);   // 3+3 -> 6,0
    @(negedge clk);
    check("bp_first_ready0", req0_ready, 1);
    exp_q.push_back({1'b0, 4'h4, 1'b0});
    tick();
    drive_req(1'b0, 4'hF, 4'd5, 2'd2, 1'b1);   // F&5 -> 5,0
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_ready0", req0_ready, 0);
      check("bp_ready1", req1_ready, 0);
      check("bp_rsp_hold", {rsp_valid, rsp_id, rsp_s, rsp_c}, {1'b1, 1'b0, 4'h4, 1'b0});
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready1", req1_ready, 1);
    exp_q.push_back({1'b1, 4'h6, 1'b0});
    tick();
    drive_req(1'b1, 4'd0, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    check("bp_next_ready0", req0_ready, 1);
    exp_q.push_back({1'b0, 4'h5, 1'b0});
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    tick();
    tick();

    // Reset mid-stream with a pending response and both requesters valid.
    rsp_ready = 1'b0;
    drive_req(1'b0, 4'd1, 4'd1, 2'd0, 1'b1);   // 1+1 -> 2,0
    @(negedge clk);
    check("mid_ready0", req0_ready, 1);
    exp_q.push_back({1'b0, 4'h2, 1'b0});
    tick();
    drive_req(1'b1, 4'd1, 4'd2, 2'd3, 1'b1);   // 1|2 -> 3,0
    @(negedge clk);
    check("mid_pending", rsp_valid, 1);
    tick();
    rst = 1'b1;
    @(negedge clk);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    tick();
    @(negedge clk);
    check("rst_discard", rsp_valid, 0);
    check("rst_ready0_b", req0_ready, 0);
    if (exp_q.size() > 0) void'(exp_q.pop_back());
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("post_rst_ready0", req0_ready, 1);
    check("post_rst_ready1", req1_ready, 0);
    exp_q.push_back({1'b0, 4'h2, 1'b0});
    tick();
    drive_req(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    @(negedge clk);
    check("post_rst_ready1_b", req1_ready, 1);
    exp_q.push_back({1'b1, 4'h3, 1'b0});
    tick();
    drive_req(1'b1, 4'd0, 4'd0, 2'd0, 1'b0);
    tick();
    tick();

`ifdef ALU4_ARB_STATS_EN
    // 256 back-to-back req0 transfers from reset wrap gnt_cnt0 to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive_req(1'b0, 4'd0, 4'd0, 2'd0, 1'b1);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      check("stats_ready0", req0_ready, 1);
      if (req0_ready) exp_q.push_back({1'b0, 4'h0, 1'b0});
      tick();
      if (i == 254) check("stats_cnt0_255", gnt_cnt0, 8'd255);
    end
    drive_req(1'b0, 4'd0, 4'd0, 2'd0, 1'b0);
    check("stats_cnt0_wrap", gnt_cnt0, 8'd0);
    check("stats_cnt1", gnt_cnt1, 8'd0);
    tick();
    tick();
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
